// File: rtl/tdm_demux4.sv
// Receive end of a 4-slot TDM link: rebuilds channels A..D from the serial word stream
// and presents each complete frame as a held output set with a one-cycle valid strobe.
module tdm_demux4 #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_sof,
    output logic [WIDTH-1:0] out_A,
    output logic [WIDTH-1:0] out_B,
    output logic [WIDTH-1:0] out_C,
    output logic [WIDTH-1:0] out_D,
    output logic             out_valid,
    output logic             frame_err,
    output logic [1:0]       slot,
    output logic [CNT_W-1:0] frame_cnt
);

    typedef enum logic {HUNT, RECV} state_t;

    state_t           state_q, state_d;
    logic [1:0]       slot_d;
    logic [WIDTH-1:0] stage0_q, stage1_q, stage2_q;
    logic [WIDTH-1:0] stage0_d, stage1_d, stage2_d;
    logic [WIDTH-1:0] out_a_d, out_b_d, out_c_d, out_d_d;
    logic             out_valid_d, frame_err_d;
    logic [CNT_W-1:0] frame_cnt_d;

    // State, staging and output registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= HUNT;
            slot      <= 2'd0;
            stage0_q  <= '0;
            stage1_q  <= '0;
            stage2_q  <= '0;
            out_A     <= '0;
            out_B     <= '0;
            out_C     <= '0;
            out_D     <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state_q   <= state_d;
            slot      <= slot_d;
            stage0_q  <= stage0_d;
            stage1_q  <= stage1_d;
            stage2_q  <= stage2_d;
            out_A     <= out_a_d;
            out_B     <= out_b_d;
            out_C     <= out_c_d;
            out_D     <= out_d_d;
            out_valid <= out_valid_d;
            frame_err <= frame_err_d;
            frame_cnt <= frame_cnt_d;
        end
    end

    // Next-state and output logic; idle cycles only clear the pulses
    always_comb begin
        state_d     = state_q;
        slot_d      = slot;
        stage0_d    = stage0_q;
        stage1_d    = stage1_q;
        stage2_d    = stage2_q;
        out_a_d     = out_A;
        out_b_d     = out_B;
        out_c_d     = out_C;
        out_d_d     = out_D;
        out_valid_d = 1'b0;
        frame_err_d = 1'b0;
        frame_cnt_d = frame_cnt;

        if (in_valid) begin
            case (state_q)
                HUNT: begin
                    if (in_sof) begin
                        stage0_d = in_data;
                        slot_d   = 2'd1;
                        state_d  = RECV;
                    end
                end
                RECV: begin
                    if (in_sof) begin
                        // Early SOF: abort the partial frame, restart with this word
                        frame_err_d = 1'b1;
                        stage0_d    = in_data;
                        slot_d      = 2'd1;
                    end else begin
                        case (slot)
                            2'd1: begin
                                stage1_d = in_data;
                                slot_d   = 2'd2;
                            end
                            2'd2: begin
                                stage2_d = in_data;
                                slot_d   = 2'd3;
                            end
                            default: begin
                                // Slot 3 commits; channel D bypasses staging
                                out_a_d     = stage0_q;
                                out_b_d     = stage1_q;
                                out_c_d     = stage2_q;
                                out_d_d     = in_data;
                                out_valid_d = 1'b1;
                                frame_cnt_d = frame_cnt + CNT_W'(1);
                                slot_d      = 2'd0;
                                state_d     = HUNT;
                            end
                        endcase
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Receive end of the 4-channel time-division link whose transmit side is a mux4 driven by a 2-bit slot counter.
- Takes the serialized word stream (one word per slot, slot 0 flagged by start-of-frame) and rebuilds the four parallel channels A/B/C/D.
- Presents each complete frame as a registered, held output set with a one-cycle valid strobe.
- Sits between the TDM link and the ALU operand registers.

Parameters:
- WIDTH, 8, bit width of each channel word.
- CNT_W, 8, width of the committed-frame counter.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- in_data  input  WIDTH  serialized slot word.
- in_valid  input  1  in_data carries a slot word this cycle.
- in_sof  input  1  start of frame; qualifies in_data as slot 0; ignored when in_valid=0.
- out_A  output  WIDTH  channel A word (slot 0) of last committed frame.
- out_B  output  WIDTH  channel B word (slot 1).
- out_C  output  WIDTH  channel C word (slot 2).
- out_D  output  WIDTH  channel D word (slot 3).
- out_valid  output  1  one-cycle pulse: out_A..out_D just updated.
- frame_err  output  1  one-cycle pulse: partial frame aborted by early in_sof.
- slot  output  2  next expected slot index (0 in HUNT).
- frame_cnt  output  CNT_W  number of committed frames, wraps modulo 2^CNT_W.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=HUNT, slot=0, staging registers=0.
  - out_A..out_D=0, out_valid=0, frame_err=0, frame_cnt=0.
  - Reset asserted mid-frame discards the partial frame; no out_valid or frame_err is produced for it.
- All outputs are registered; everything below happens on a rising clock edge with reset_n=1.
- A beat is a cycle with in_valid=1. Cycles with in_valid=0 change nothing except clearing the pulses. Gaps of any length are allowed mid-frame; there is no timeout.
- out_valid and frame_err default to 0 every cycle and are high only in the cycle after the event that sets them.
- HUNT state:
  - Beat with in_sof=1: stage[0]<=in_data, slot<=1, go to RECV.
  - Beat with in_sof=0: word dropped silently, stay in HUNT.
- RECV state, beat with in_sof=0 and slot in {1,2}: stage[slot]<=in_data, slot<=slot+1.
- RECV state, beat with in_sof=0 and slot=3 (commit):
  - out_A<=stage[0], out_B<=stage[1], out_C<=stage[2], out_D<=in_data (bypass, not via staging).
  - out_valid<=1, frame_cnt<=frame_cnt+1, slot<=0, go to HUNT.
  - Latency: outputs and out_valid are visible in the cycle after the slot-3 beat.
- RECV state, beat with in_sof=1 (early start of frame, any slot 1..3):
  - frame_err<=1; the partial frame is discarded and out_A..out_D are unchanged.
  - The current word is taken as slot 0 of a new frame: stage[0]<=in_data, slot<=1, stay in RECV.
- Back-to-back frames: a slot-0 beat in the cycle immediately after a commit is accepted normally; full throughput is 1 frame per 4 cycles.
- frame_cnt wraps from 2^CNT_W-1 to 0 with no flag.
- Outputs hold the last committed frame indefinitely; a subsequent partial or aborted frame never disturbs them.

Test Plan:
- Reset, then 4 consecutive beats 0x11(sof),0x22,0x33,0x44 -> next cycle out_A..D=11/22/33/44, out_valid=1 for exactly one cycle, frame_cnt=1, slot=0.
- Same frame with 3 idle cycles between each beat -> identical outputs; out_valid only after the 0x44 beat; slot reads 1,2,3 during the gaps.
- In HUNT, beats 0xAA,0xBB without sof, then frame 1,2,3,4 -> AA/BB are dropped, output 01/02/03/04, no frame_err.
- Frame 0x10(sof),0x20, then 0x50(sof),0x60,0x70,0x80 -> frame_err pulse after the 0x50 beat; out_A..D unchanged, then 50/60/70/80 with one out_valid; frame_cnt increments once.
- Mid-frame reset after beats 0x01(sof),0x02, release, send 0x09(sof),0x08,0x07,0x06 -> outputs 0 during and after reset, no out_valid or frame_err for the aborted frame, then 09/08/07/06 committed.
- 256 back-to-back frames with CNT_W=8 -> out_valid every 4th cycle, frame_cnt wraps to 0 after the 256th frame.
